fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Sequences instruction fetch for the MIPS pipeline. Owns the PC and drives a single-outstanding instruction-bus request/response handshake. Delivers {pc, instruction} to decode through a valid/ready slot. Applies taken branch/jump redirects with MIPS delay-slot semantics: the delay-slot instruction at branch_pc+4 is always delivered, and the target is fetched immediately after it.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
PC_STEP, 4, sequential PC increment in bytes

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ireq_valid  out  1  instruction-bus request valid
ireq_addr  out  32  request address
ireq_ready  in  1  bus accepts the request this cycle
iresp_valid  in  1  read data returned for the accepted request
iresp_data  in  32  instruction word
out_valid  out  1  fetched instruction available to decode
out_pc  out  32  PC of the delivered instruction
out_instr  out  32  delivered instruction
out_ready  in  1  decode consumes the slot when out_valid && out_ready
redirect_valid  in  1  single-cycle pulse: branch/jump resolved taken
redirect_pc  in  32  address B of the branch/jump instruction
redirect_target  in  32  target address T

Behaviour:
- Reset (reset is synchronous, active-high; clock clk):
  - state=REQ, cur_pc=RESET_PC, pending redirect cleared, drop flag cleared.
  - ireq_valid=0 during the reset cycle; out_valid=0; out_pc=0; out_instr=0.
- State machine, one request outstanding at most:
  - REQ: ireq_valid=1, ireq_addr=cur_pc; ireq_addr is held stable until ireq_ready. On ireq_ready go to WAIT.
  - WAIT: ireq_valid=0. On iresp_valid:
    - drop flag set: discard the data, clear drop, go to REQ.
    - otherwise: register out_pc=cur_pc and out_instr=iresp_data, go to HOLD.
  - HOLD: out_valid=1. On out_ready: set cur_pc=next_pc, go to REQ in the next cycle.
- Latency: minimum 3 cycles from request issue to out_valid with a zero-wait bus (REQ, WAIT with same-cycle response, HOLD).
- next_pc:
  - cur_pc+PC_STEP, modulo 2^32; wrap from 32'hFFFF_FFFC to 0 is silent.
  - When a pending redirect is armed for the current address, next_pc=T instead.
- Redirect, evaluated on the redirect_valid cycle with D=redirect_pc+4 against cur_pc (the address currently in REQ, WAIT or HOLD):
  - cur_pc==D (delay slot in the slot): keep it, deliver it normally, arm pending redirect; the next address issued is T.
  - cur_pc!=D (delay slot already delivered; slot holds a wrong-path instruction), by state:
    - REQ, not yet accepted: retarget, cur_pc=T next cycle.
    - REQ with ireq_ready the same cycle: treat as WAIT.
    - WAIT: set drop; cur_pc=T; the response is discarded and T is issued.
    - HOLD: out_valid=0 next cycle and the slot is squashed even if out_ready was high that cycle; cur_pc=T; go to REQ.
- Simultaneous events:
  - Redirect in the same cycle as iresp_valid in WAIT: the response is compared like any WAIT-state fetch. Delivered if cur_pc==D, dropped otherwise.
  - Redirect in the same cycle as the HOLD handshake with cur_pc==D: D completes, the next request is T.
  - A new redirect while one is pending replaces it.
- out_pc and out_instr are stable while out_valid && !out_ready.
- Reset in any state abandons in-flight work immediately. The instruction bus is reset on the same reset, so no stale response follows.

Test Plan:
- Sequential fetch, zero-wait bus, out_ready=1 after reset -> requests at 0x0, 0x4, 0x8; out_pc 0x0, 0x4, 0x8 each with the matching iresp_data; first out_valid 3 cycles after reset release.
- Back-pressure: out_ready=0 for 5 cycles while out_valid at pc 0x4 -> out_pc/out_instr stable, ireq_valid=0, no new request until the handshake.
- Delay slot in slot: redirect B=0x10, T=0x100 while HOLD at 0x14 -> 0x14 delivered, next ireq_addr=0x100, then 0x104.
- Wrong-path squash in WAIT: redirect B=0x10, T=0x200 while WAIT at 0x18 -> response for 0x18 never appears on out_*, next ireq_addr=0x200.
- Squash in HOLD with out_ready=1 same cycle: redirect B=0x20, T=0x40 while HOLD at 0x28 -> 0x28 not consumed, next request 0x40.
- Reset mid-WAIT, then wrap: reset asserted in WAIT -> out_valid=0, next request RESET_PC. Redirect to T=0xFFFF_FFFC -> following request 0x0.

Source files
------------

// File: rtl/fetch_ctrl_if.sv
// Fetch-side handshake bundle: instruction bus, decode slot and branch redirect.
interface fetch_ctrl_if;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        ireq_ready;
  logic        iresp_valid;
  logic [31:0] iresp_data;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] redirect_target;

  modport master (
    output ireq_valid, ireq_addr, out_valid, out_pc, out_instr,
    input  ireq_ready, iresp_valid, iresp_data, out_ready,
           redirect_valid, redirect_pc, redirect_target
  );

  modport slave (
    input  ireq_valid, ireq_addr, out_valid, out_pc, out_instr,
    output ireq_ready, iresp_valid, iresp_data, out_ready,
           redirect_valid, redirect_pc, redirect_target
  );
endinterface

// File: rtl/fetch_ctrl.sv
// MIPS fetch sequencer: owns the PC, one outstanding bus request, single decode slot,
// and taken-branch redirects honouring the delay slot.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic         clk,
  input  logic         reset,
  fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } slot_t;

  state_t      state;
  logic [31:0] cur_pc;
  logic        pend_valid;
  logic [31:0] pend_target;
  logic        drop;
  logic        slot_valid;
  slot_t       slot;

  logic [31:0] dslot_pc;
  logic        redir_hit;
  logic        redir_miss;
  logic [31:0] seq_pc;
  logic [31:0] hold_next_pc;

  // A redirect whose delay slot is cur_pc keeps the slot; anything else is wrong-path.
  assign dslot_pc     = bus.redirect_pc + 32'd4;
  assign redir_hit    = bus.redirect_valid && (cur_pc == dslot_pc);
  assign redir_miss   = bus.redirect_valid && (cur_pc != dslot_pc);
  assign seq_pc       = pend_valid ? pend_target : cur_pc + 32'(PC_STEP);
  assign hold_next_pc = redir_hit ? bus.redirect_target : seq_pc;

  // Request is withheld while reset is held so the bus never sees a stray request.
  assign bus.ireq_valid = (state == S_REQ) && !reset;
  assign bus.ireq_addr  = cur_pc;
  assign bus.out_valid  = slot_valid;
  assign bus.out_pc     = slot.pc;
  assign bus.out_instr  = slot.instr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_REQ;
      cur_pc      <= RESET_PC;
      pend_valid  <= 1'b0;
      pend_target <= '0;
      drop        <= 1'b0;
      slot_valid  <= 1'b0;
      slot        <= '0;
    end else begin
      // Later assignments below override this when the slot completes the same cycle.
      if (redir_hit) begin
        pend_valid  <= 1'b1;
        pend_target <= bus.redirect_target;
      end
      unique case (state)
        S_REQ: begin
          if (redir_miss) begin
            cur_pc     <= bus.redirect_target;
            pend_valid <= 1'b0;
            if (bus.ireq_ready) begin
              drop  <= 1'b1;
              state <= S_WAIT;
            end
          end else if (bus.ireq_ready) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (redir_miss) begin
            cur_pc     <= bus.redirect_target;
            pend_valid <= 1'b0;
            if (bus.iresp_valid) begin
              drop  <= 1'b0;
              state <= S_REQ;
            end else begin
              drop <= 1'b1;
            end
          end else if (bus.iresp_valid) begin
            if (drop) begin
              drop  <= 1'b0;
              state <= S_REQ;
            end else begin
              slot_valid  <= 1'b1;
              slot.pc     <= cur_pc;
              slot.instr  <= bus.iresp_data;
              state       <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (redir_miss) begin
            slot_valid <= 1'b0;
            cur_pc     <= bus.redirect_target;
            pend_valid <= 1'b0;
            state      <= S_REQ;
          end else if (bus.out_ready) begin
            slot_valid <= 1'b0;
            cur_pc     <= hold_next_pc;
            pend_valid <= 1'b0;
            state      <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: bus model plus request/delivery scoreboards,
// a redirect scenario table and hand-written reset/back-pressure sequences.
module tb_fetch_ctrl;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int ST_REQ  = 0;
  localparam int ST_WAIT = 1;
  localparam int ST_HOLD = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_ctrl_if bus();

  fetch_ctrl #(.RESET_PC(RESET_PC), .PC_STEP(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          lat;
    int          gap;
    logic [31:0] b;
    logic [31:0] t;
    logic [31:0] trig_pc;
    int          trig_st;
    bit          rdy_trig;
    bit          req_trig;
    bit          dlv_trig;
    logic [31:0] nxt;
  } vec_t;

  int          n_chk = 0;
  int          n_pass = 0;
  int          bus_lat = 0;
  int          ready_gap = 0;
  int          rwait = 0;
  int          cnt = 0;
  bit          outst = 1'b0;
  logic [31:0] raddr = '0;
  logic [31:0] exp_pc;
  logic [31:0] exp_req[$];
  logic [31:0] exp_out[$];

  function automatic logic [31:0] instr_of(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
  endtask

  // Bus model and scoreboard monitors, all sampled mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      outst           = 1'b0;
      rwait           = 0;
      bus.iresp_valid = 1'b0;
      bus.iresp_data  = '0;
      bus.ireq_ready  = 1'b0;
    end else begin
      bus.iresp_valid = 1'b0;
      if (outst) begin
        if (cnt == 0) begin
          bus.iresp_valid = 1'b1;
          bus.iresp_data  = instr_of(raddr);
          outst           = 1'b0;
        end else begin
          cnt--;
        end
      end
      bus.ireq_ready = bus.ireq_valid && (rwait >= ready_gap);
      if (bus.ireq_valid && !bus.ireq_ready) rwait++;
      if (bus.ireq_valid && bus.ireq_ready) begin
        chk("single_outstanding", 32'(outst), 32'd0);
        outst = 1'b1;
        raddr = bus.ireq_addr;
        cnt   = bus_lat;
        rwait = 0;
        if (exp_req.size() != 0) chk("req_addr", bus.ireq_addr, exp_req.pop_front());
      end
      // A wrong-path redirect squashes the slot even if out_ready is high.
      if (bus.out_valid && bus.out_ready &&
          !(bus.redirect_valid && bus.out_pc != bus.redirect_pc + 32'd4)) begin
        if (exp_out.size() != 0) begin
          exp_pc = exp_out.pop_front();
          chk("out_pc", bus.out_pc, exp_pc);
          chk("out_instr", bus.out_instr, instr_of(exp_pc));
        end
      end
    end
  end

  task automatic do_reset(int lat, int gap);
    reset               = 1'b1;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;
    bus.redirect_target = '0;
    bus.out_ready       = 1'b1;
    bus_lat             = lat;
    ready_gap           = gap;
    exp_req.delete();
    exp_out.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ireq_valid", 32'(bus.ireq_valid), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_pc", bus.out_pc, 32'd0);
    chk("rst_out_instr", bus.out_instr, 32'd0);
    reset = 1'b0;
    #1;
  endtask

  task automatic drain(string tag);
    int n;
    n = 0;
    while ((exp_out.size() != 0 || exp_req.size() != 0) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_out_left"}, 32'(exp_out.size()), 32'd0);
    chk({tag, "_req_left"}, 32'(exp_req.size()), 32'd0);
  endtask

  function automatic bit at_trig(vec_t v);
    case (v.trig_st)
      ST_REQ:  return bus.ireq_valid && bus.ireq_addr == v.trig_pc;
      ST_WAIT: return !bus.ireq_valid && !bus.out_valid && outst && raddr == v.trig_pc;
      default: return bus.out_valid && bus.out_pc == v.trig_pc;
    endcase
  endfunction

  vec_t vecs[10];
  vec_t v;
  int   n;

  initial begin
    reset               = 1'b1;
    bus.out_ready       = 1'b1;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;
    bus.redirect_target = '0;

    //          lat gap b         t             trig     state    rdy  req  dlv  next
    vecs[0] = '{0, 0, 32'h10, 32'h100,      32'h14, ST_HOLD, 1'b1, 1'b1, 1'b1, 32'h100};
    vecs[1] = '{0, 0, 32'h10, 32'h180,      32'h14, ST_HOLD, 1'b0, 1'b1, 1'b1, 32'h180};
    vecs[2] = '{2, 0, 32'h10, 32'h200,      32'h18, ST_WAIT, 1'b1, 1'b1, 1'b0, 32'h200};
    vecs[3] = '{0, 0, 32'h14, 32'h300,      32'h18, ST_WAIT, 1'b1, 1'b1, 1'b1, 32'h300};
    vecs[4] = '{0, 0, 32'h08, 32'h340,      32'h18, ST_WAIT, 1'b1, 1'b1, 1'b0, 32'h340};
    vecs[5] = '{0, 0, 32'h20, 32'h40,       32'h28, ST_HOLD, 1'b1, 1'b1, 1'b0, 32'h40};
    vecs[6] = '{0, 2, 32'h00, 32'h400,      32'h10, ST_REQ,  1'b1, 1'b0, 1'b0, 32'h400};
    vecs[7] = '{1, 0, 32'h00, 32'h440,      32'h10, ST_REQ,  1'b1, 1'b1, 1'b0, 32'h440};
    vecs[8] = '{0, 1, 32'h0C, 32'h480,      32'h10, ST_REQ,  1'b1, 1'b1, 1'b1, 32'h480};
    vecs[9] = '{0, 0, 32'h04, 32'hFFFF_FFFC, 32'h08, ST_HOLD, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC};

    // Sequential fetch, 3-cycle first delivery, then back-pressure at pc 0x4.
    do_reset(0, 0);
    exp_req = '{32'h0, 32'h4, 32'h8, 32'hC};
    exp_out = '{32'h0, 32'h4, 32'h8};
    chk("seq_c1_ireq_valid", 32'(bus.ireq_valid), 32'd1);
    chk("seq_c1_ireq_addr", bus.ireq_addr, RESET_PC);
    chk("seq_c1_out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    chk("seq_c2_out_valid", 32'(bus.out_valid), 32'd0);
    chk("seq_c2_ireq_valid", 32'(bus.ireq_valid), 32'd0);
    @(posedge clk); #1;
    chk("seq_c3_out_valid", 32'(bus.out_valid), 32'd1);
    n = 0;
    while (!(bus.out_valid && bus.out_pc == 32'h4) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_reach_pc4", 32'(n < 50), 32'd1);
    bus.out_ready = 1'b0;
    repeat (5) begin
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_out_pc", bus.out_pc, 32'h4);
      chk("bp_out_instr", bus.out_instr, instr_of(32'h4));
      chk("bp_no_req", 32'(bus.ireq_valid), 32'd0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    drain("seq");

    // Redirect scenarios from the table.
    for (int i = 0; i < 10; i++) begin
      v = vecs[i];
      do_reset(v.lat, v.gap);
      for (int a = 0; a < int'(v.trig_pc); a += 4) begin
        exp_req.push_back(32'(a));
        exp_out.push_back(32'(a));
      end
      if (v.req_trig) exp_req.push_back(v.trig_pc);
      if (v.dlv_trig) exp_out.push_back(v.trig_pc);
      n = 0;
      while (!at_trig(v) && n < 150) begin
        @(posedge clk); #1;
        n++;
      end
      chk("redir_trig_reached", 32'(n < 150), 32'd1);
      bus.redirect_valid  = 1'b1;
      bus.redirect_pc     = v.b;
      bus.redirect_target = v.t;
      if (v.trig_st == ST_HOLD) bus.out_ready = v.rdy_trig;
      exp_req.push_back(v.nxt);
      exp_req.push_back(v.nxt + 32'd4);
      exp_out.push_back(v.nxt);
      exp_out.push_back(v.nxt + 32'd4);
      @(posedge clk); #1;
      bus.redirect_valid = 1'b0;
      if (v.trig_st == ST_HOLD && !v.dlv_trig)
        chk("redir_squash_out_valid", 32'(bus.out_valid), 32'd0);
      bus.out_ready = 1'b1;
      drain("redir");
    end

    // Reset while a request is in flight: the bus answer never arrives, fetch restarts.
    do_reset(3, 0);
    n = 0;
    while (!(!bus.ireq_valid && !bus.out_valid && outst && raddr == 32'h8) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rstwait_reached", 32'(n < 100), 32'd1);
    reset = 1'b1;
    #1;
    chk("rstwait_ireq_valid", 32'(bus.ireq_valid), 32'd0);
    @(posedge clk); #1;
    chk("rstwait_out_valid", 32'(bus.out_valid), 32'd0);
    reset = 1'b0;
    #1;
    chk("rstwait_ireq_valid_after", 32'(bus.ireq_valid), 32'd1);
    chk("rstwait_ireq_addr", bus.ireq_addr, RESET_PC);
    exp_out = '{32'h0, 32'h4};
    drain("rstwait");

    // Reset while the slot is held: the slot is cleared immediately.
    n = 0;
    while (!(bus.out_valid && bus.out_pc == 32'hC) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rsthold_reached", 32'(n < 100), 32'd1);
    bus.out_ready = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rsthold_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rsthold_out_pc", bus.out_pc, 32'd0);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("rsthold_ireq_addr", bus.ireq_addr, RESET_PC);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
